rr_decode_arbiter: RTL and testbench



---
 rtl/rr_decode_arbiter_if.sv | 23 ++
 rtl/rr_decode_arbiter.sv | 102 ++++++++++
 tb/tb_rr_decode_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_decode_arbiter_if #(
  parameter int IDX_W = 3
);
  localparam int N = 2 ** IDX_W;

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    input  grant, grant_idx, grant_valid, busy, timeout
  );

  modport slave (
    input  req,
    output grant, grant_idx, grant_valid, busy, timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 2**IDX_W requesters with a registered index,
// its one-hot decode, and a hold timeout that bounds any single ownership.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no owner; arbitrate among requests each edge from r_ptr up
// S_GRANT | r_grant_idx owns the resource; leave on req drop or timeout
module rr_decode_arbiter #(
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_decode_arbiter_if.slave  bus
);
  localparam int N = 2 ** IDX_W;
  localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [N-1:0]        r_grant;
  logic                r_grant_valid;
  logic                r_timeout;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic [IDX_W-1:0]    w_pick;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;

  // Circular priority search: scanning offsets from high to low lets the
  // smallest offset from r_ptr overwrite the others, so it wins.
  always_comb begin
    w_pick = r_ptr;
    w_idx  = r_ptr;
    w_any  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = r_ptr + IDX_W'(k);
      if (bus.req[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  // Arbitration FSM; every output is a register so consumers see clean levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_grant_idx   <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_hold_cnt    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state       <= S_GRANT;
            r_grant_idx   <= w_pick;
            r_grant       <= ONE_HOT_0 << w_pick;
            r_grant_valid <= 1'b1;
            r_ptr         <= w_pick + 1'b1;
            r_hold_cnt    <= HOLD_W'(1);
          end
        end
        S_GRANT: begin
          if (!bus.req[r_grant_idx]) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
          end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_W'(MAX_HOLD))) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b1;
          end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
            // With the timeout enabled the count never passes MAX_HOLD;
            // with it disabled it just parks at all-ones.
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.grant_valid = r_grant_valid;
  assign bus.busy        = r_grant_valid;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios plus sticky random requests,
// every cycle compared against an ownership-level reference model.
module tb_rr_decode_arbiter;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;
  localparam int HOLD_W   = 5;
  localparam int N        = 8;
  localparam int STARVE_LIMIT = 7 * (MAX_HOLD + 1);

  logic clk;
  logic rst_n;

  rr_decode_arbiter_if #(.IDX_W(IDX_W)) bus();

  rr_decode_arbiter #(
    .IDX_W   (IDX_W),
    .MAX_HOLD(MAX_HOLD),
    .HOLD_W  (HOLD_W)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the resource, for how long, and where the
  // round-robin search starts next time.
  int m_owner;
  int m_ptr;
  int m_held;
  int m_last_idx;
  bit m_to;

  int wait_cnt[N];
  int max_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_held     = 0;
    m_last_idx = 0;
    m_to       = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit found;
    if (m_owner < 0) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int d = 0; d < N; d++) begin
        if (!found && r[(m_ptr + d) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + d) % N;
        end
      end
      if (found) begin
        m_ptr      = (m_owner + 1) % N;
        m_held     = 1;
        m_last_idx = m_owner;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
      m_to    = 1'b0;
    end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
      m_to = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_grant;
    exp_grant = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk("grant", bus.grant, exp_grant);
    chk("grant_idx", bus.grant_idx, m_last_idx);
    chk("grant_valid", bus.grant_valid, m_owner >= 0);
    chk("busy", bus.busy, m_owner >= 0);
    chk("timeout", bus.timeout, m_to);
    chk("onehot", $countones(bus.grant) <= 1, 1);
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] && !(bus.grant_valid && bus.grant_idx == i)) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  // One clock: drive req at the falling edge, let the DUT and model take the
  // rising edge, then compare at the next falling edge.
  task automatic cycle(input logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    int run;
    bit seen;

    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    max_wait = 0;
    bus.req = 8'h00;
    rst_n   = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_grant", bus.grant, 8'h00);
    chk("rst_idx", bus.grant_idx, 0);
    chk("rst_valid", bus.grant_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester held four cycles, then dropped.
    for (int c = 0; c < 4; c++) begin
      cycle(8'h08);
      chk("single_grant", bus.grant, 8'h08);
    end
    cycle(8'h00);
    chk("single_clear", bus.grant, 8'h00);

    // Next requester above index 3 shows the pointer moved to 4.
    cycle(8'h19);
    chk("single_ptr", bus.grant_idx, 4);

    // Asynchronous reset in the middle of a grant.
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", bus.grant, 8'h00);
    chk("async_valid", bus.grant_valid, 0);
    chk("async_timeout", bus.timeout, 0);
    model_reset();
    bus.req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h20);
    chk("post_rst_grant", bus.grant, 8'h20);
    chk("post_rst_idx", bus.grant_idx, 5);
    cycle(8'h00);

    // Pointer at 6: index 7 wins over 0, then the pointer wraps to 0.
    cycle(8'h81);
    chk("wrap_first", bus.grant_idx, 7);
    cycle(8'h01);
    chk("wrap_gap", bus.grant, 8'h00);
    cycle(8'h01);
    chk("wrap_second", bus.grant_idx, 0);
    cycle(8'h00);

    // Round robin with everyone requesting; each owner steps aside briefly.
    do_reset();
    for (int k = 0; k <= N; k++) begin
      cycle(8'hFF);
      chk("rr_order", bus.grant_idx, k % N);
      cycle(8'hFF);
      r = 8'hFF;
      r[k % N] = 1'b0;
      cycle(r);
      chk("rr_gap", bus.grant, 8'h00);
    end

    // Timeout on a sole requester, then re-grant after one dead cycle.
    do_reset();
    run  = 0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      cycle(8'h04);
      if (bus.timeout) seen = 1'b1;
      else if (bus.grant == 8'h04) run++;
    end
    chk("to_seen", seen, 1);
    chk("to_len", run, MAX_HOLD);
    chk("to_gap_grant", bus.grant, 8'h00);
    cycle(8'h04);
    chk("to_regrant", bus.grant, 8'h04);

    // Timeout with a competitor: the next index in rotation wins.
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      cycle(8'h0C);
      if (bus.timeout) seen = 1'b1;
    end
    chk("to2_seen", seen, 1);
    cycle(8'h0C);
    chk("to2_next", bus.grant_idx, 3);
    cycle(8'h00);

    // Sticky random requests: bits flip rarely so ownerships run long.
    do_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    max_wait = 0;
    r = 8'($urandom);
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(15, 0) == 0) r[b] = ~r[b];
      cycle(r);
    end
    chk("starve_bound", max_wait <= STARVE_LIMIT, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
